// File: rtl/integrated.sv
`default_nettype none
// ============================================================================
// Module   : integrated
// Brief    : N x N output-stationary systolic matrix multiplier, C = A x B,
//            using internal constant operands and a registered result array.
// Revision : 1.0 - initial release
// ============================================================================
module integrated #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 2*DW + $clog2(N)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic finish
);

    localparam int              CW          = $clog2(3*N);
    localparam logic [CW-1:0]   c_feed_last = CW'(3*N - 1);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_clear = 3'd1;
    localparam logic [2:0] c_feed  = 3'd2;
    localparam logic [2:0] c_store = 3'd3;
    localparam logic [2:0] c_done  = 3'd4;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;

    logic [DW-1:0] r_a      [N][N];
    logic [DW-1:0] r_b      [N][N];
    logic [AW-1:0] r_acc    [N][N];
    logic [AW-1:0] r_result [N][N];

    logic [DW-1:0] w_a_edge [N];
    logic [DW-1:0] w_b_edge [N];
    logic [DW-1:0] w_a_in   [N][N];
    logic [DW-1:0] w_b_in   [N][N];

    logic w_clear;
    logic w_feed;
    logic w_store;

    assign w_clear = (r_state == c_clear);
    assign w_feed  = (r_state == c_feed);
    assign w_store = (r_state == c_store);

    // Skewed edge feed: row/column k lags by k cycles so operands meet in step.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_a_edge[i] = '0;
            w_b_edge[i] = '0;
            if (w_feed && (int'(r_cnt) >= i) && (int'(r_cnt) - i < N)) begin
                w_a_edge[i] = DW'(i*N + (int'(r_cnt) - i) + 1);
                w_b_edge[i] = DW'(i + 1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_a_in[i][0] = w_a_edge[i];
            w_b_in[0][i] = w_b_edge[i];
            for (int j = 1; j < N; j++) begin
                w_a_in[i][j] = r_a[i][j-1];
                w_b_in[j][i] = r_b[j-1][i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            finish  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) r_state <= c_clear;
                end
                c_clear: begin
                    r_cnt   <= '0;
                    r_state <= c_feed;
                end
                c_feed: begin
                    if (r_cnt == c_feed_last) begin
                        r_cnt   <= '0;
                        r_state <= c_store;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_store: begin
                    r_state <= c_done;
                    finish  <= 1'b1;
                end
                c_done: begin
                    if (!start) begin
                        r_state <= c_idle;
                        finish  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    finish  <= 1'b0;
                end
            endcase
        end
    end

    // PE grid: operand pipeline, accumulators and result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_a[i][j]      <= '0;
                    r_b[i][j]      <= '0;
                    r_acc[i][j]    <= '0;
                    r_result[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_a[i][j] <= w_a_in[i][j];
                    r_b[i][j] <= w_b_in[i][j];
                    if (w_clear) begin
                        r_acc[i][j] <= '0;
                    end else if (w_feed) begin
                        r_acc[i][j] <= r_acc[i][j] + AW'(w_a_in[i][j]) * AW'(w_b_in[i][j]);
                    end
                    if (w_store) begin
                        r_result[i][j] <= r_acc[i][j];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_integrated.sv
`default_nettype none
// ============================================================================
// Module   : tb_integrated
// Brief    : Scoreboard bench for the systolic multiplier: expected finish
//            times are queued at start, a monitor checks latency and results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_integrated;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int AW  = 2*DW + $clog2(N);
    localparam int LAT = 3*N + 3;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic finish;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int q_due[$];
    int mon_d;
    logic fin_q = 1'b0;

    integrated #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .finish (finish)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j] with A = i*N+k+1, B = j+1.
    function automatic int model_c(input int i, input int j);
        int s = 0;
        for (int k = 0; k < N; k++) s += (i*N + k + 1) * (j + 1);
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
        end
    endtask

    task automatic check_result(input bit zero);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("result_%0d_%0d", i, j), 64'(dut.r_result[i][j]),
                      zero ? 64'd0 : 64'(model_c(i, j)));
    endtask

    // Monitor: every rising finish must match the oldest outstanding run.
    always @(negedge clk) begin
        if (finish === 1'b1 && fin_q !== 1'b1) begin
            if (q_due.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_finish actual_cycle=%0d expected=none", cyc);
            end else begin
                mon_d = q_due.pop_front();
                check("finish_latency", 64'(cyc), 64'(mon_d));
                check_result(1'b0);
            end
        end
        fin_q = finish;
    end

    task automatic idle_quiet(input int n, input string name);
        int hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (finish !== 1'b0) hi++;
        end
        check(name, 64'(hi), 64'd0);
    endtask

    // mode 0: hold start, 1: one-cycle pulse, 2: random toggling while busy
    task automatic run(input int mode);
        int h;
        @(negedge clk);
        start = 1'b1;
        q_due.push_back(cyc + LAT);
        for (int k = 0; k < LAT - 1; k++) begin
            @(negedge clk);
            case (mode)
                0:       start = 1'b1;
                1:       start = 1'b0;
                default: start = 1'($urandom_range(0, 1));
            endcase
        end
        @(negedge clk);
        check("finish_rise", 64'(finish), 64'd1);
        if (mode == 0) begin
            h = $urandom_range(1, 4);
            repeat (h) begin
                @(negedge clk);
                check("finish_hold", 64'(finish), 64'd1);
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("finish_fall", 64'(finish), 64'd0);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check("finish_idle", 64'(finish), 64'd0);
        check_result(1'b0);
        check("finish_seen", 64'(q_due.size()), 64'd0);
        q_due.delete();
    endtask

    task automatic abort_run();
        int n;
        @(negedge clk);
        start = 1'b1;
        q_due.push_back(cyc + LAT);
        n = $urandom_range(3, 10);
        repeat (n) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
        end
        #2;
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check("abort_finish", 64'(finish), 64'd0);
        check_result(1'b1);
        q_due.delete();
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_quiet(20, "abort_quiet");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_finish", 64'(finish), 64'd0);
        check_result(1'b1);
        rst = 1'b1;
        idle_quiet(3000, "idle_finish");
        check_result(1'b1);

        run(0);
        run(1);
        run(2);
        abort_run();
        run(0);
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 4) == 0) abort_run();
            run(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
